// File: rtl/read_stage_pkg.sv
// +----------------------------------------------------------------------------+
// | read_stage_pkg: shared codes and helpers for the operand-read stage.        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package read_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int PC_W   = 31;
  localparam int IMM_W  = 5;

  // Branch condition codes
  localparam logic [2:0] CMP_ALWAYS = 3'b000;
  localparam logic [2:0] CMP_EQ     = 3'b001;
  localparam logic [2:0] CMP_NE     = 3'b010;
  localparam logic [2:0] CMP_LT     = 3'b011;
  localparam logic [2:0] CMP_GE     = 3'b100;
  localparam logic [2:0] CMP_LTU    = 3'b101;
  localparam logic [2:0] CMP_GEU    = 3'b110;
  localparam logic [2:0] CMP_NEVER  = 3'b111;

  // Branch-target source selects
  localparam logic [1:0] PCSRC_PAIR = 2'b00;
  localparam logic [1:0] PCSRC_B    = 2'b01;
  localparam logic [1:0] PCSRC_IMM  = 2'b10;
  localparam logic [1:0] PCSRC_A    = 2'b11;

  function automatic logic [DATA_W-1:0] sext_imm16(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  function automatic logic branch_cond(input logic [2:0]        code,
                                       input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
    logic c;
    c = 1'b0;
    case (code)
      CMP_ALWAYS: c = 1'b1;
      CMP_EQ:     c = (a == b);
      CMP_NE:     c = (a != b);
      CMP_LT:     c = ($signed(a) <  $signed(b));
      CMP_GE:     c = ($signed(a) >= $signed(b));
      CMP_LTU:    c = (a <  b);
      CMP_GEU:    c = (a >= b);
      CMP_NEVER:  c = 1'b0;
      default:    c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/read_fwd.sv
// +----------------------------------------------------------------------------+
// | read_fwd: three-way operand bypass (exe result, wb result, register file). |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module read_fwd
  import read_stage_pkg::*;
(
  input  logic [REG_W-1:0]  reg_idx,
  input  logic [DATA_W-1:0] rf_value,
  input  logic [DATA_W-1:0] exe_out,
  input  logic [REG_W-1:0]  exe_dst_reg,
  input  logic              exe_en,
  input  logic [DATA_W-1:0] wb_out,
  input  logic [REG_W-1:0]  wb_dst_reg,
  input  logic              wb_en,
  output logic [DATA_W-1:0] value
);

  logic w_exe_hit;
  logic w_wb_hit;

  assign w_exe_hit = exe_en && (exe_dst_reg == reg_idx);
  assign w_wb_hit  = wb_en  && (wb_dst_reg  == reg_idx);

  // Youngest producer wins: exe result is newer than the writeback result.
  always_comb begin
    value = rf_value;
    if (w_exe_hit)
      value = exe_out;
    else if (w_wb_hit)
      value = wb_out;
  end

endmodule

`default_nettype wire

// File: rtl/read_stage.sv
// +----------------------------------------------------------------------------+
// | read_stage: operand read, forwarding, branch evaluation, execute pipe reg. |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module read_stage
  import read_stage_pkg::*;
(
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              imm_en,
  input  logic [IMM_W-1:0]  arg_imm,
  input  logic              read_a,
  input  logic [REG_W-1:0]  arg_a,
  input  logic              read_b,
  input  logic [REG_W-1:0]  arg_b,
  input  logic [2:0]        cmp_b,
  input  logic              pc_set,
  input  logic              pc_add,
  input  logic              pc_inc,
  input  logic [1:0]        pc_src,
  input  logic [1:0]        en_regs,
  input  logic              i_alu_en,
  input  logic [3:0]        i_truth_table,
  input  logic [4:0]        i_alu_op,
  input  logic              sh_off_imm,
  input  logic              i_mem_en,
  input  logic              i_mem_write,
  input  logic [DATA_W-1:0] exe_out,
  input  logic [REG_W-1:0]  exe_dst_reg,
  input  logic              exe_en,
  input  logic [DATA_W-1:0] wb_out,
  input  logic [REG_W-1:0]  wb_dst_reg,
  input  logic              wb_en,
  input  logic [DATA_W-1:0] reg_a_value,
  input  logic [DATA_W-1:0] reg_b_value,
  output logic              reg_a_read,
  output logic [REG_W-1:0]  reg_a,
  output logic              reg_b_read,
  output logic [REG_W-1:0]  reg_b,
  output logic              src_a_en,
  output logic              src_b_en,
  output logic [DATA_W-1:0] src_a,
  output logic [DATA_W-1:0] src_b,
  output logic              o_pc_set,
  output logic              o_pc_add,
  output logic              o_pc_inc,
  output logic [PC_W-1:0]   pc,
  output logic              o_alu_en,
  output logic [3:0]        o_truth_table,
  output logic [4:0]        o_alu_op,
  output logic [3:0]        sh_off,
  output logic              o_mem_en,
  output logic              o_mem_write,
  output logic [31:0]       mem_addr
);

  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_cond;
  logic [PC_W-1:0]   w_target;
  logic [3:0]        w_sh_off;

  assign reg_a_read = read_a;
  assign reg_a      = arg_a;
  assign reg_b_read = read_b;
  assign reg_b      = arg_b;

  read_fwd u_fwd_a (
    .reg_idx     (arg_a),
    .rf_value    (reg_a_value),
    .exe_out     (exe_out),
    .exe_dst_reg (exe_dst_reg),
    .exe_en      (exe_en),
    .wb_out      (wb_out),
    .wb_dst_reg  (wb_dst_reg),
    .wb_en       (wb_en),
    .value       (w_fwd_a)
  );

  read_fwd u_fwd_b (
    .reg_idx     (arg_b),
    .rf_value    (reg_b_value),
    .exe_out     (exe_out),
    .exe_dst_reg (exe_dst_reg),
    .exe_en      (exe_en),
    .wb_out      (wb_out),
    .wb_dst_reg  (wb_dst_reg),
    .wb_en       (wb_en),
    .value       (w_fwd_b)
  );

  always_comb begin
    w_a = read_a ? w_fwd_a : '0;
    if (imm_en)
      w_b = sext_imm16(arg_imm);
    else if (read_b)
      w_b = w_fwd_b;
    else
      w_b = '0;
  end

  assign w_cond   = branch_cond(cmp_b, w_a, w_b);
  assign w_sh_off = sh_off_imm ? arg_imm[3:0] : w_b[3:0];

  // PAIR concatenates the low 15 bits of A with B to fill the 31-bit target.
  always_comb begin
    w_target = '0;
    case (pc_src)
      PCSRC_PAIR: w_target = {w_a[14:0], w_b};
      PCSRC_B:    w_target = {{(PC_W-DATA_W){w_b[DATA_W-1]}}, w_b};
      PCSRC_IMM:  w_target = {{(PC_W-IMM_W){arg_imm[IMM_W-1]}}, arg_imm};
      PCSRC_A:    w_target = {{(PC_W-DATA_W){1'b0}}, w_a};
      default:    w_target = '0;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      src_a         <= '0;
      src_b         <= '0;
      src_a_en      <= 1'b0;
      src_b_en      <= 1'b0;
      o_pc_set      <= 1'b0;
      o_pc_add      <= 1'b0;
      o_pc_inc      <= 1'b0;
      pc            <= '0;
      o_alu_en      <= 1'b0;
      o_truth_table <= '0;
      o_alu_op      <= '0;
      sh_off        <= '0;
      o_mem_en      <= 1'b0;
      o_mem_write   <= 1'b0;
      mem_addr      <= '0;
    end else begin
      src_a         <= w_a;
      src_b         <= w_b;
      src_a_en      <= en_regs[0];
      src_b_en      <= en_regs[1];
      o_pc_set      <= pc_set & w_cond;
      o_pc_add      <= pc_add & w_cond;
      o_pc_inc      <= pc_inc;
      pc            <= w_target;
      o_alu_en      <= i_alu_en;
      o_truth_table <= i_truth_table;
      o_alu_op      <= i_alu_op;
      sh_off        <= w_sh_off;
      o_mem_en      <= i_mem_en;
      o_mem_write   <= i_mem_write;
      mem_addr      <= {w_a, w_b};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_read_stage.sv
// Self-checking bench for read_stage: directed scenarios plus randomized traffic
// against an arithmetic reference model.
`default_nettype none

module tb_read_stage;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        imm_en;
  logic [4:0]  arg_imm;
  logic        read_a, read_b;
  logic [3:0]  arg_a, arg_b;
  logic [2:0]  cmp_b;
  logic        pc_set, pc_add, pc_inc;
  logic [1:0]  pc_src, en_regs;
  logic        i_alu_en;
  logic [3:0]  i_truth_table;
  logic [4:0]  i_alu_op;
  logic        sh_off_imm, i_mem_en, i_mem_write;
  logic [15:0] exe_out, wb_out, reg_a_value, reg_b_value;
  logic [3:0]  exe_dst_reg, wb_dst_reg;
  logic        exe_en, wb_en;

  logic        reg_a_read, reg_b_read;
  logic [3:0]  reg_a, reg_b;
  logic        src_a_en, src_b_en;
  logic [15:0] src_a, src_b;
  logic        o_pc_set, o_pc_add, o_pc_inc;
  logic [30:0] pc;
  logic        o_alu_en;
  logic [3:0]  o_truth_table;
  logic [4:0]  o_alu_op;
  logic [3:0]  sh_off;
  logic        o_mem_en, o_mem_write;
  logic [31:0] mem_addr;

  int checks   = 0;
  int failures = 0;

  always #5 cpu_clk = ~cpu_clk;

  read_stage dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .imm_en(imm_en), .arg_imm(arg_imm),
    .read_a(read_a), .arg_a(arg_a), .read_b(read_b), .arg_b(arg_b), .cmp_b(cmp_b),
    .pc_set(pc_set), .pc_add(pc_add), .pc_inc(pc_inc), .pc_src(pc_src),
    .en_regs(en_regs), .i_alu_en(i_alu_en), .i_truth_table(i_truth_table),
    .i_alu_op(i_alu_op), .sh_off_imm(sh_off_imm), .i_mem_en(i_mem_en),
    .i_mem_write(i_mem_write), .exe_out(exe_out), .exe_dst_reg(exe_dst_reg),
    .exe_en(exe_en), .wb_out(wb_out), .wb_dst_reg(wb_dst_reg), .wb_en(wb_en),
    .reg_a_value(reg_a_value), .reg_b_value(reg_b_value),
    .reg_a_read(reg_a_read), .reg_a(reg_a), .reg_b_read(reg_b_read), .reg_b(reg_b),
    .src_a_en(src_a_en), .src_b_en(src_b_en), .src_a(src_a), .src_b(src_b),
    .o_pc_set(o_pc_set), .o_pc_add(o_pc_add), .o_pc_inc(o_pc_inc), .pc(pc),
    .o_alu_en(o_alu_en), .o_truth_table(o_truth_table), .o_alu_op(o_alu_op),
    .sh_off(sh_off), .o_mem_en(o_mem_en), .o_mem_write(o_mem_write),
    .mem_addr(mem_addr)
  );

  // All registered outputs as one vector, for reset checks.
  wire [115:0] all_regs = {src_a, src_b, src_a_en, src_b_en, o_pc_set, o_pc_add,
                           o_pc_inc, pc, o_alu_en, o_truth_table, o_alu_op, sh_off,
                           o_mem_en, o_mem_write, mem_addr};

  // ---------------- reference model ----------------
  function automatic logic [15:0] m_fwd(input logic [3:0] r, input logic [15:0] rf);
    if (exe_en && exe_dst_reg == r) return exe_out;
    if (wb_en && wb_dst_reg == r) return wb_out;
    return rf;
  endfunction

  function automatic logic [15:0] m_a();
    return read_a ? m_fwd(arg_a, reg_a_value) : 16'd0;
  endfunction

  function automatic logic [15:0] m_b();
    int v;
    if (imm_en) begin
      v = int'(arg_imm);
      if (v >= 16) v = v - 32;
      return 16'(v);
    end
    return read_b ? m_fwd(arg_b, reg_b_value) : 16'd0;
  endfunction

  function automatic logic m_cond(input logic [15:0] a, input logic [15:0] b);
    int sa, sb, ua, ub;
    ua = int'(a); ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    case (cmp_b)
      3'd0: return 1'b1;
      3'd1: return ua == ub;
      3'd2: return ua != ub;
      3'd3: return sa < sb;
      3'd4: return sa >= sb;
      3'd5: return ua < ub;
      3'd6: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [30:0] m_pc(input logic [15:0] a, input logic [15:0] b);
    longint v;
    case (pc_src)
      2'd0: v = longint'(a % 32768) * 65536 + longint'(b);
      2'd1: v = (b >= 16'h8000) ? longint'(b) - 65536 : longint'(b);
      2'd2: v = (arg_imm >= 5'd16) ? longint'(arg_imm) - 32 : longint'(arg_imm);
      default: v = longint'(a);
    endcase
    return 31'(v);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    imm_en = 0; arg_imm = 0; read_a = 0; arg_a = 0; read_b = 0; arg_b = 0;
    cmp_b = 0; pc_set = 0; pc_add = 0; pc_inc = 0; pc_src = 0; en_regs = 0;
    i_alu_en = 0; i_truth_table = 0; i_alu_op = 0; sh_off_imm = 0;
    i_mem_en = 0; i_mem_write = 0; exe_out = 0; exe_dst_reg = 0; exe_en = 0;
    wb_out = 0; wb_dst_reg = 0; wb_en = 0; reg_a_value = 0; reg_b_value = 0;
  endtask

  task automatic randomize_inputs();
    imm_en = 1'($urandom); arg_imm = 5'($urandom); read_a = 1'($urandom);
    arg_a = 4'($urandom_range(0, 3)); read_b = 1'($urandom);
    arg_b = 4'($urandom_range(0, 3)); cmp_b = 3'($urandom);
    pc_set = 1'($urandom); pc_add = 1'($urandom); pc_inc = 1'($urandom);
    pc_src = 2'($urandom); en_regs = 2'($urandom); i_alu_en = 1'($urandom);
    i_truth_table = 4'($urandom); i_alu_op = 5'($urandom);
    sh_off_imm = 1'($urandom); i_mem_en = 1'($urandom); i_mem_write = 1'($urandom);
    exe_out = 16'($urandom); exe_dst_reg = 4'($urandom_range(0, 3));
    exe_en = 1'($urandom); wb_out = 16'($urandom);
    wb_dst_reg = 4'($urandom_range(0, 3)); wb_en = 1'($urandom);
    reg_a_value = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
    reg_b_value = ($urandom_range(0, 3) == 0) ? reg_a_value : 16'($urandom);
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cpu_rst = 0;
    randomize_inputs();
    tick(); tick();
    checks++;
    if (all_regs !== '0) begin
      failures++; $display("FAIL reset_regs: got %h want 0", all_regs);
    end
    checks++;
    if ({reg_a_read, reg_a, reg_b_read, reg_b} !== {read_a, arg_a, read_b, arg_b}) begin
      failures++;
      $display("FAIL reset_reqs: got %b want %b", {reg_a_read, reg_a, reg_b_read, reg_b},
               {read_a, arg_a, read_b, arg_b});
    end
    // Asynchronous assertion mid-cycle after outputs were loaded
    cpu_rst = 1;
    clear_inputs();
    read_a = 1; reg_a_value = 16'hBEEF; i_mem_en = 1; pc_inc = 1; en_regs = 2'b11;
    tick();
    #2 cpu_rst = 0;
    #1;
    checks++;
    if (all_regs !== '0) begin
      failures++; $display("FAIL reset_async: got %h want 0", all_regs);
    end
    @(negedge cpu_clk);
    cpu_rst = 1;
    clear_inputs();
    read_a = 1; arg_a = 4'd3; reg_a_value = 16'h1234;
    #1;
    checks++;
    if (reg_a !== 4'd3 || reg_a_read !== 1'b1) begin
      failures++; $display("FAIL reg_req: got %0d/%b want 3/1", reg_a, reg_a_read);
    end
    tick();
    checks++;
    if (src_a !== 16'h1234) begin
      failures++; $display("FAIL first_read: got %h want 1234", src_a);
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    read_a = 1; arg_a = 4'd5; reg_a_value = 16'h5555;
    exe_en = 1; exe_dst_reg = 4'd5; exe_out = 16'hAAAA;
    wb_en = 1; wb_dst_reg = 4'd5; wb_out = 16'hBBBB;
    tick();
    checks++;
    if (src_a !== 16'hAAAA) begin
      failures++; $display("FAIL fwd_exe: got %h want aaaa", src_a);
    end
    exe_en = 0;
    tick();
    checks++;
    if (src_a !== 16'hBBBB) begin
      failures++; $display("FAIL fwd_wb: got %h want bbbb", src_a);
    end
    wb_en = 0;
    tick();
    checks++;
    if (src_a !== 16'h5555) begin
      failures++; $display("FAIL fwd_rf: got %h want 5555", src_a);
    end
  endtask

  task automatic test_immediate();
    clear_inputs();
    read_b = 1; reg_b_value = 16'h0123;
    imm_en = 1; arg_imm = 5'b10011; sh_off_imm = 1;
    tick();
    checks++;
    if (src_b !== 16'hFFF3) begin
      failures++; $display("FAIL imm_sext: got %h want fff3", src_b);
    end
    checks++;
    if (sh_off !== 4'd3) begin
      failures++; $display("FAIL sh_off_imm: got %0d want 3", sh_off);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    pc_set = 1; read_a = 1; arg_a = 4'd1; read_b = 1; arg_b = 4'd2;
    reg_a_value = 16'd7; reg_b_value = 16'd7; cmp_b = 3'b001;
    tick();
    checks++;
    if (o_pc_set !== 1'b1) begin
      failures++; $display("FAIL br_eq_taken: got %b want 1", o_pc_set);
    end
    reg_b_value = 16'd8;
    tick();
    checks++;
    if (o_pc_set !== 1'b0) begin
      failures++; $display("FAIL br_eq_not: got %b want 0", o_pc_set);
    end
    reg_a_value = 16'hFFFF; reg_b_value = 16'd1; cmp_b = 3'b011;
    tick();
    checks++;
    if (o_pc_set !== 1'b1) begin
      failures++; $display("FAIL br_lt_signed: got %b want 1", o_pc_set);
    end
    cmp_b = 3'b101;
    tick();
    checks++;
    if (o_pc_set !== 1'b0) begin
      failures++; $display("FAIL br_lt_unsigned: got %b want 0", o_pc_set);
    end
  endtask

  task automatic test_mem_pc();
    clear_inputs();
    i_mem_en = 1; read_a = 1; arg_a = 4'd1; read_b = 1; arg_b = 4'd2;
    reg_a_value = 16'h0001; reg_b_value = 16'h8000; pc_src = 2'b00;
    tick();
    checks++;
    if (mem_addr !== 32'h00018000 || o_mem_en !== 1'b1) begin
      failures++; $display("FAIL mem_addr: got %h/%b want 00018000/1", mem_addr, o_mem_en);
    end
    checks++;
    if (pc !== 31'h00018000) begin
      failures++; $display("FAIL pc_pair: got %h want 00018000", pc);
    end
  endtask

  task automatic test_random();
    logic [15:0] ea, eb;
    logic        c;
    logic [30:0] epc;
    logic [22:0] ectl, actl;
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      #1;
      ea = m_a(); eb = m_b(); c = m_cond(ea, eb); epc = m_pc(ea, eb);
      ectl = {en_regs[1], en_regs[0], pc_set & c, pc_add & c, pc_inc, i_alu_en,
              i_truth_table, i_alu_op, sh_off_imm ? arg_imm[3:0] : eb[3:0],
              i_mem_en, i_mem_write};
      tick();
      actl = {src_b_en, src_a_en, o_pc_set, o_pc_add, o_pc_inc, o_alu_en,
              o_truth_table, o_alu_op, sh_off, o_mem_en, o_mem_write};
      checks++;
      if (src_a !== ea || src_b !== eb) begin
        failures++; $display("FAIL rnd_src[%0d]: got %h %h want %h %h", i, src_a, src_b, ea, eb);
      end
      checks++;
      if (pc !== epc) begin
        failures++; $display("FAIL rnd_pc[%0d]: got %h want %h (src %0d)", i, pc, epc, pc_src);
      end
      checks++;
      if (mem_addr !== {ea, eb}) begin
        failures++; $display("FAIL rnd_mem[%0d]: got %h want %h", i, mem_addr, {ea, eb});
      end
      checks++;
      if (actl !== ectl) begin
        failures++; $display("FAIL rnd_ctl[%0d]: got %h want %h (cmp %0d)", i, actl, ectl, cmp_b);
      end
    end
  endtask

  initial begin
    clear_inputs();
    cpu_rst = 0;
    test_reset();
    test_forwarding();
    test_immediate();
    test_branch();
    test_mem_pc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/read_stage.md
# read_stage

Operand-read stage of the 16-bit pipelined CPU (RTL module `read`), between decode and execute. Drives the register-file read ports and resolves operands with exe/wb forwarding. Forms immediate, shift-offset, branch-target and memory-address values, evaluates the branch condition, and registers everything into the execute-stage pipeline register.

## Interface
Parameters: none.
- cpu_clk in 1: stage clock, rising edge.
- cpu_rst in 1: asynchronous, active-low reset.
- imm_en in 1: operand B comes from immediate.
- arg_imm in 5: immediate field.
- read_a in 1; arg_a in 4: read operand A; register index.
- read_b in 1; arg_b in 4: read operand B; register index.
- cmp_b in 3: branch condition code.
- pc_set, pc_add, pc_inc in 1 each: PC-control requests.
- pc_src in 2: branch-target source select.
- en_regs in 2: bit0 enables src_a, bit1 enables src_b.
- i_alu_en in 1; i_truth_table in 4; i_alu_op in 5: ALU controls.
- sh_off_imm in 1: shift offset from immediate.
- i_mem_en, i_mem_write in 1 each: memory controls.
- exe_out in 16; exe_dst_reg in 4; exe_en in 1: execute-stage result bypass.
- wb_out in 16; wb_dst_reg in 4; wb_en in 1: writeback bypass.
- reg_a_value, reg_b_value in 16: register-file read data (combinational).
- reg_a_read, reg_b_read out 1; reg_a, reg_b out 4: register-file read requests.
- src_a_en, src_b_en out 1; src_a, src_b out 16: operands.
- o_pc_set, o_pc_add, o_pc_inc out 1; pc out 31: PC controls and target.
- o_alu_en out 1; o_truth_table out 4; o_alu_op out 5; sh_off out 4.
- o_mem_en, o_mem_write out 1; mem_addr out 32.

## Operation
- Register requests are combinational: reg_a_read=read_a, reg_a=arg_a, reg_b_read=read_b, reg_b=arg_b.
- Forwarded value for index r, computed per operand:
  - exe_out if exe_en and exe_dst_reg==r;
  - otherwise wb_out if wb_en and wb_dst_reg==r;
  - otherwise the register-file value.
  - Exe has priority over wb. Register 0 gets no special treatment.
- A = forwarded(arg_a) if read_a, otherwise 0.
- B = sign-extended arg_imm if imm_en. Otherwise forwarded(arg_b) if read_b, otherwise 0.
- Condition C over A,B, selected by cmp_b:
  - 000 always; 001 A==B; 010 A!=B;
  - 011 A<B signed; 100 A>=B signed;
  - 101 A<B unsigned; 110 A>=B unsigned; 111 never.
- Branch target by pc_src:
  - 00: {A[14:0],B};
  - 01: B sign-extended to 31 bits;
  - 10: arg_imm sign-extended;
  - 11: A zero-extended.
- Register inputs on each rising edge:
  - src_a=A, src_b=B, src_a_en=en_regs[0], src_b_en=en_regs[1];
  - o_pc_set = pc_set&C, o_pc_add = pc_add&C, o_pc_inc = pc_inc;
  - pc = target;
  - ALU and memory controls pass through;
  - sh_off = sh_off_imm ? arg_imm[3:0] : B[3:0];
  - mem_addr = {A,B}.

## Timing
- Register requests: 0-cycle combinational. All other outputs: exactly 1 cycle after inputs.
- No stall or handshake. The stage accepts new inputs every cycle.
- Forwarding uses the exe/wb inputs present in the same cycle as the decode fields.
- Reset drops every registered output to 0 immediately, independent of the clock. It stays 0 until the first edge after release.
- Reset mid-operation discards in-flight values. Register-request outputs still follow their inputs during reset.

## Structure
- Shared package holds:
  - cmp_b codes (CMP_ALWAYS … CMP_NEVER);
  - pc_src codes (PCSRC_PAIR, PCSRC_B, PCSRC_IMM, PCSRC_A).
- One sub-module, `read_fwd`: combinational 3-way bypass mux, instantiated once per operand.

## Test plan
- Reset low with random inputs -> all registered outputs 0. Release, read_a=1, arg_a=3, reg_a_value=0x1234 -> next edge src_a=0x1234, reg_a=3.
- Forwarding, arg_a=5:
  - exe_en=1, exe_dst_reg=5, exe_out=0xAAAA; wb_en=1, wb_dst_reg=5, wb_out=0xBBBB -> src_a=0xAAAA.
  - exe_en=0 -> src_a=0xBBBB.
- imm_en=1, arg_imm=5'b10011 -> src_b=0xFFF3. sh_off_imm=1 -> sh_off=3.
- pc_set=1, cmp_b=001:
  - A=B=7 -> o_pc_set=1.
  - A=7, B=8 -> o_pc_set=0.
  - cmp_b=011, A=0xFFFF, B=1 -> 1 (signed). cmp_b=101 with the same operands -> 0.
- i_mem_en=1, A=0x0001, B=0x8000 -> mem_addr=0x00018000, o_mem_en=1. pc_src=00 -> pc=31'h00018000.
